if_id_fetch_queue: RTL and testbench

//   Prefetch queue between the instruction-fetch stage and the decode stage.

---
 rtl/if_id_fetch_queue_if.sv | 26 ++
 rtl/if_id_fetch_queue.sv | 126 ++++++++++++
 tb/tb_if_id_fetch_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID prefetch queue.
// The queue connects through the slave modport; the fetch/decode side uses master.
interface if_id_fetch_queue_if #(
    parameter int AW = 2
);
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [AW:0] count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID prefetch queue: DEPTH-entry circular buffer of {pc, instr} pairs.
// A flush discards every queued entry in one cycle.
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_id_fetch_queue_if.slave   q
);
    localparam logic [AW:0]   FULL_C  = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   count_r;

    logic          empty_s;
    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;
    logic [63:0]   head_s;

    assign empty_s    = (count_r == {(AW+1){1'b0}});
    assign in_ready_s = (count_r != FULL_C) && !q.flush;
    assign push_s     = q.in_valid && in_ready_s;
    assign pop_s      = !empty_s && q.out_ready;

    assign q.in_ready  = in_ready_s;
    assign q.out_valid = !empty_s;
    assign q.count     = count_r;
    assign q.out_pc    = head_s[63:32];
    assign q.out_instr = head_s[31:0];

    // Head entry is forced to zero while empty so decode never sees stale data.
    always_comb begin
        head_s = 64'd0;
        if (!empty_s) begin
            head_s = mem_r[rp_r];
        end else begin
            head_s = 64'd0;
        end
    end

    // Pointer and occupancy state; flush outranks any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else if (q.flush) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents survive a flush since the pointers make them unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else if (push_s) begin
            mem_r[wp_r] <= {q.in_pc, q.in_instr};
        end
    end

    if_id_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wp    (wp_r),
        .rp    (rp_r),
        .count (count_r)
    );
endmodule

// Occupancy invariant: count tracks the pointer distance, DEPTH only when pointers meet.
module if_id_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [AW-1:0] wp,
    input logic [AW-1:0] rp,
    input logic [AW:0]   count
);
    localparam logic [AW:0] FULL_C = DEPTH[AW:0];

    logic [AW-1:0] diff_s;
    logic          ok_s;

    // Evaluate the invariant for the current pointer/count state.
    always_comb begin
        diff_s = wp - rp;
        ok_s   = 1'b0;
        if (count == FULL_C) begin
            ok_s = (wp == rp);
        end else if (count < FULL_C) begin
            ok_s = (count[AW-1:0] == diff_s);
        end else begin
            ok_s = 1'b0;
        end
    end

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n) ok_s)
        else $error("fetch queue occupancy invariant violated: wp=%0d rp=%0d count=%0d", wp, rp, count);
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: a reference queue predicts every output.
module tb_if_id_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [63:0] mq [$];

    always #5 clk = ~clk;

    if_id_fetch_queue_if #(.AW(AW)) bus ();

    if_id_fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus.slave)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs(input logic fl);
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'd0;
        check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        check_eq("in_ready",  64'(bus.in_ready),  64'((mq.size() < DEPTH) && !fl));
        check_eq("count",     64'(bus.count),     64'(mq.size()));
        check_eq("out_pc",    64'(bus.out_pc),    64'(head[63:32]));
        check_eq("out_instr", 64'(bus.out_instr), 64'(head[31:0]));
    endtask

    // One clock: drive away from the edge, check predicted outputs, advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic fl, output logic acc);
        logic push;
        logic pop;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr_of(pc);
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        compare_outputs(fl);
        acc = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            push = v && (mq.size() < DEPTH);
            pop  = rdy && (mq.size() != 0);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back({pc, instr_of(pc)});
            acc = push;
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] next_pc;
        int          sent;

        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset state
        #2;
        compare_outputs(1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        // Fill to full, fifth push dropped, then drain in order
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0, acc);
        check_eq("full_count", 64'(bus.count), 64'd4);
        repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        // Simultaneous push and pop at count 2
        cycle(1'b1, 32'd24, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd28, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd40, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);
        check_eq("simul_count", 64'(bus.count), 64'd2);
        repeat (2) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        // Flush with a concurrent push, then a normal push afterwards
        cycle(1'b1, 32'd60, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd64, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd68, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd100, 1'b1, 1'b1, acc);
        cycle(1'b1, 32'd200, 1'b0, 1'b0, acc);
        check_eq("post_flush_count", 64'(bus.count), 64'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        // Flush while empty
        cycle(1'b1, 32'd204, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        // Streaming with toggling out_ready: pointers wrap
        next_pc = 32'd300;
        sent    = 0;
        for (int i = 0; i < 40 && sent < 10; i++) begin
            cycle(1'b1, next_pc, (i % 2) == 0, 1'b0, acc);
            check_eq("wrap_count_le4", 64'(bus.count <= 3'(DEPTH)), 64'd1);
            if (acc) begin
                next_pc = next_pc + 32'd4;
                sent++;
            end
        end
        repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-cycle with two entries queued
        cycle(1'b1, 32'd500, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd504, 1'b0, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_count",     64'(bus.count),     64'd0);
        check_eq("arst_out_pc",    64'(bus.out_pc),    64'd0);
        check_eq("arst_in_ready",  64'(bus.in_ready),  64'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'd600, 1'b0, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
